// File: rtl/shixu_detector.sv
// Moore detector for the 2-bit symbol sequence 1,2,3,1 with overlap.
// ans is decoded from the state register only, so it changes only after clock edges.
module shixu_detector (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] num,
    output logic       ans
);

    typedef enum logic [2:0] {
        S0   = 3'd0,
        S1   = 3'd1,
        S12  = 3'd2,
        S123 = 3'd3,
        HIT  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S0;
        unique case (state)
            S0: begin
                if (num == 2'd1) state_next = S1;
            end
            // The final 1 of a match also starts the next candidate, so HIT behaves as S1.
            S1, HIT: begin
                if (num == 2'd1)      state_next = S1;
                else if (num == 2'd2) state_next = S12;
            end
            S12: begin
                if (num == 2'd1)      state_next = S1;
                else if (num == 2'd3) state_next = S123;
            end
            S123: begin
                if (num == 2'd1) state_next = HIT;
            end
            default: state_next = S0;
        endcase
    end

    assign ans = (state == HIT);

endmodule

// File: tb/tb_shixu_detector.sv
// Directed bench for shixu_detector: a table of {reset, num, expected ans}
// vectors plus a hand-written sequence with inputs changing between edges.
module tb_shixu_detector;

    logic       clk;
    logic       reset;
    logic [1:0] num;
    logic       ans;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic       rst;
        logic [1:0] sym;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    shixu_detector dut (
        .clk   (clk),
        .reset (reset),
        .num   (num),
        .ans   (ans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [1:0] s, input logic e);
        vec_t v;
        v.rst = r;
        v.sym = s;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: ans=%b expected=%b at time %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        num    = 2'd0;

        // Reset held two edges with num=1; that 1 must be discarded.
        add(1, 1, 0); add(1, 1, 0);
        add(0, 2, 0); add(0, 3, 0); add(0, 1, 0);
        // Basic match, pulse lasts one cycle.
        add(1, 0, 0);
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 1, 1); add(0, 0, 0);
        // Mixed stream: hits after symbols 12 and 17.
        add(0, 0, 0); add(0, 1, 0); add(0, 1, 0); add(0, 2, 0); add(0, 1, 0);
        add(0, 2, 0); add(0, 1, 0); add(0, 3, 0); add(0, 1, 0); add(0, 2, 0);
        add(0, 3, 0); add(0, 1, 1); add(0, 2, 0); add(0, 1, 0); add(0, 2, 0);
        add(0, 3, 0); add(0, 1, 1);
        add(0, 0, 0);
        // Overlap: hits after symbols 4 and 7.
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 1, 1);
        add(0, 2, 0); add(0, 3, 0); add(0, 1, 1);
        add(0, 0, 0);
        // HIT followed by 1 still progresses as S1.
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 1, 1);
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 1, 1);
        add(0, 0, 0);
        // Breakers, then prove the trailing 1 left the machine in S1.
        add(0, 1, 0); add(0, 2, 0); add(0, 2, 0); add(0, 3, 0); add(0, 1, 0);
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 3, 0); add(0, 1, 0);
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 0, 0); add(0, 1, 0);
        add(0, 2, 0); add(0, 3, 0); add(0, 1, 1);
        add(0, 0, 0);
        // Reset mid-sequence discards progress.
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(1, 1, 0);
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 1, 1);
        add(0, 0, 0);
        // Reset on the completing edge wins; nothing carries over.
        add(0, 1, 0); add(0, 2, 0); add(0, 3, 0); add(1, 1, 0);
        add(0, 2, 0); add(0, 3, 0); add(0, 1, 0);
        add(0, 0, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            num   = vecs[i].sym;
            @(posedge clk);
            #1;
            check($sformatf("vec[%0d]", i), ans, vecs[i].exp);
        end

        // Inputs wander between edges; only the value at the edge counts.
        begin
            logic [1:0] seq [4];
            logic       ex  [4];
            seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd1;
            ex[0]  = 1'b0; ex[1]  = 1'b0; ex[2]  = 1'b0; ex[3]  = 1'b1;
            reset = 1'b0;
            num   = 2'd0;
            @(posedge clk);
            #1;
            check("glitch_pre", ans, 1'b0);
            for (int k = 0; k < 4; k++) begin
                num = 2'd0;
                #2;
                num = 2'd3;
                #2;
                num = seq[k];
                @(posedge clk);
                #1;
                check($sformatf("glitch_step%0d", k), ans, ex[k]);
                @(negedge clk);
                check($sformatf("glitch_mid%0d", k), ans, ex[k]);
            end
            num = 2'd3;
            @(posedge clk);
            #1;
            check("glitch_drop", ans, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
